// File: rtl/decode_pipe_stage.sv
// PIPE Y86-64 decode stage: field decode, D->E pipeline register, load-use
// interlock, mispredict flush, sticky halt and a saturating stall counter.
module decode_pipe_stage #(
  parameter int              RW    = 4,
  parameter logic [RW-1:0]   RNONE = {RW{1'b1}},
  parameter int              RSP   = 4,
  parameter int              CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_valid,
  input  logic [3:0]      d_icode,
  input  logic [RW-1:0]   d_rA,
  input  logic [RW-1:0]   d_rB,
  output logic            d_ready,
  output logic [RW-1:0]   d_srcA,
  output logic [RW-1:0]   d_srcB,
  input  logic            e_cnd,
  input  logic            e_flush,
  output logic            e_valid,
  output logic [3:0]      e_icode,
  output logic [RW-1:0]   e_srcA,
  output logic [RW-1:0]   e_srcB,
  output logic [RW-1:0]   e_dstE,
  output logic [RW-1:0]   e_dstM,
  output logic            halted,
  output logic [CNTW-1:0] stall_count
);

  localparam logic [RW-1:0] RSP_IDX = RW'(RSP);

  localparam logic [3:0] IHALT  = 4'h0;
  localparam logic [3:0] INOP   = 4'h1;
  localparam logic [3:0] IRRMOV = 4'h2;
  localparam logic [3:0] IIRMOV = 4'h3;
  localparam logic [3:0] IRMMOV = 4'h4;
  localparam logic [3:0] IMRMOV = 4'h5;
  localparam logic [3:0] IOPQ   = 4'h6;
  localparam logic [3:0] ICALL  = 4'h8;
  localparam logic [3:0] IRET   = 4'h9;
  localparam logic [3:0] IPUSH  = 4'hA;
  localparam logic [3:0] IPOP   = 4'hB;

  logic [RW-1:0] dec_srcA, dec_srcB, dec_dstE, dec_dstM;

  logic            e_valid_q, e_valid_d;
  logic [3:0]      e_icode_q, e_icode_d;
  logic [RW-1:0]   e_srcA_q, e_srcA_d;
  logic [RW-1:0]   e_srcB_q, e_srcB_d;
  logic [RW-1:0]   e_dstE_q, e_dstE_d;
  logic [RW-1:0]   e_dstM_q, e_dstM_d;
  logic            halted_q, halted_d;
  logic [CNTW-1:0] stall_count_q, stall_count_d;

  logic load_in_e, hazard, hold_e;

  always_comb begin
    dec_srcA = RNONE;
    dec_srcB = RNONE;
    dec_dstE = RNONE;
    dec_dstM = RNONE;
    case (d_icode)
      IRRMOV, IRMMOV, IOPQ, IPUSH: dec_srcA = d_rA;
      IRET, IPOP:                  dec_srcA = RSP_IDX;
      default:                     dec_srcA = RNONE;
    endcase
    case (d_icode)
      IRMMOV, IMRMOV, IOPQ:        dec_srcB = d_rB;
      ICALL, IRET, IPUSH, IPOP:    dec_srcB = RSP_IDX;
      default:                     dec_srcB = RNONE;
    endcase
    case (d_icode)
      IRRMOV, IIRMOV, IOPQ:        dec_dstE = d_rB;
      ICALL, IRET, IPUSH, IPOP:    dec_dstE = RSP_IDX;
      default:                     dec_dstE = RNONE;
    endcase
    case (d_icode)
      IMRMOV, IPOP:                dec_dstM = d_rA;
      default:                     dec_dstM = RNONE;
    endcase
  end

  assign d_srcA = d_valid ? dec_srcA : RNONE;
  assign d_srcB = d_valid ? dec_srcB : RNONE;

  assign load_in_e = e_valid_q & ((e_icode_q == IMRMOV) | (e_icode_q == IPOP))
                     & (e_dstM_q != RNONE);
  assign hazard    = d_valid & load_in_e & ((d_srcA == e_dstM_q) | (d_srcB == e_dstM_q));
  assign hold_e    = e_valid_q & (e_icode_q == IHALT);
  assign d_ready   = ~reset & ~halted_q & ~hold_e & (~hazard | e_flush);

  always_comb begin
    e_valid_d     = 1'b0;
    e_icode_d     = INOP;
    e_srcA_d      = RNONE;
    e_srcB_d      = RNONE;
    e_dstE_d      = RNONE;
    e_dstM_d      = RNONE;
    halted_d      = halted_q;
    stall_count_d = stall_count_q;
    // Every branch except a clean accept leaves the bubble defaults in place.
    if (e_flush) begin
      halted_d = halted_q;
    end else if (hold_e) begin
      halted_d = 1'b1;
    end else if (halted_q) begin
      halted_d = 1'b1;
    end else if (hazard) begin
      if (stall_count_q != {CNTW{1'b1}}) stall_count_d = stall_count_q + CNTW'(1);
    end else if (d_valid) begin
      e_valid_d = 1'b1;
      e_icode_d = d_icode;
      e_srcA_d  = dec_srcA;
      e_srcB_d  = dec_srcB;
      e_dstE_d  = dec_dstE;
      e_dstM_d  = dec_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q     <= 1'b0;
      e_icode_q     <= INOP;
      e_srcA_q      <= RNONE;
      e_srcB_q      <= RNONE;
      e_dstE_q      <= RNONE;
      e_dstM_q      <= RNONE;
      halted_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      e_valid_q     <= e_valid_d;
      e_icode_q     <= e_icode_d;
      e_srcA_q      <= e_srcA_d;
      e_srcB_q      <= e_srcB_d;
      e_dstE_q      <= e_dstE_d;
      e_dstM_q      <= e_dstM_d;
      halted_q      <= halted_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign e_valid     = e_valid_q;
  assign e_icode     = e_icode_q;
  assign e_srcA      = e_srcA_q;
  assign e_srcB      = e_srcB_q;
  // A cmov whose condition failed must not write its destination.
  assign e_dstE      = (e_valid_q && (e_icode_q == IRRMOV) && !e_cnd) ? RNONE : e_dstE_q;
  assign e_dstM      = e_dstM_q;
  assign halted      = halted_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Scoreboard bench for decode_pipe_stage: directed plan items plus random
// instruction streams, with a narrow-counter instance to exercise saturation.
module tb_decode_pipe_stage;

  typedef struct {
    logic [3:0] icode;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [3:0] de;
    logic [3:0] dm;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0;
  logic [3:0] d_icode = 4'h1;
  logic [3:0] d_rA = 4'hF;
  logic [3:0] d_rB = 4'hF;
  logic       e_cnd = 1'b0;
  logic       e_flush = 1'b0;

  logic        d_ready;
  logic [3:0]  d_srcA, d_srcB;
  logic        e_valid;
  logic [3:0]  e_icode, e_srcA, e_srcB, e_dstE, e_dstM;
  logic        halted;
  logic [15:0] stall_count;

  logic        s_d_ready, s_e_valid, s_halted;
  logic [3:0]  s_d_srcA, s_d_srcB, s_e_icode, s_e_srcA, s_e_srcB, s_e_dstE, s_e_dstM;
  logic [1:0]  s_stall_count;

  always #5 clk = ~clk;

  decode_pipe_stage u_dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_icode(d_icode), .d_rA(d_rA), .d_rB(d_rB),
    .d_ready(d_ready), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_cnd(e_cnd), .e_flush(e_flush),
    .e_valid(e_valid), .e_icode(e_icode), .e_srcA(e_srcA), .e_srcB(e_srcB), .e_dstE(e_dstE),
    .e_dstM(e_dstM), .halted(halted), .stall_count(stall_count)
  );

  decode_pipe_stage #(.CNTW(2)) u_sat (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_icode(d_icode), .d_rA(d_rA), .d_rB(d_rB),
    .d_ready(s_d_ready), .d_srcA(s_d_srcA), .d_srcB(s_d_srcB), .e_cnd(e_cnd), .e_flush(e_flush),
    .e_valid(s_e_valid), .e_icode(s_e_icode), .e_srcA(s_e_srcA), .e_srcB(s_e_srcB),
    .e_dstE(s_e_dstE), .e_dstM(s_e_dstM), .halted(s_halted), .stall_count(s_stall_count)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 0;
  ent_t sb[$];
  ent_t mon_ex;

  // Reference state: what E holds, whether halted, and an unbounded stall tally.
  bit   m_ev = 0;
  ent_t m_e;
  bit   m_halted = 0;
  int   m_cnt = 0;
  bit   last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    ent_t r;
    r.icode = ic;
    r.sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    r.sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    r.de = (ic inside {4'h2, 4'h3, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    r.dm = (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    return r;
  endfunction

  task automatic step(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                      input logic [3:0] rb, input logic cnd, input logic fl,
                      input logic rs, input bit do_chk);
    ent_t dd;
    logic [3:0] esa, esb, edste;
    bit haz, hold, rdy;
    @(negedge clk);
    reset = rs; d_valid = v; d_icode = ic; d_rA = ra; d_rB = rb; e_cnd = cnd; e_flush = fl;
    #1;
    dd   = decode(ic, ra, rb);
    esa  = v ? dd.sa : 4'hF;
    esb  = v ? dd.sb : 4'hF;
    haz  = v && m_ev && (m_e.icode == 4'h5 || m_e.icode == 4'hB) && m_e.dm != 4'hF
           && (esa == m_e.dm || esb == m_e.dm);
    hold = m_ev && m_e.icode == 4'h0;
    rdy  = !rs && !m_halted && !hold && (!haz || fl);
    edste = !m_ev ? 4'hF : (m_e.icode == 4'h2 && !cnd) ? 4'hF : m_e.de;
    if (do_chk) begin
      chk("d_ready", d_ready, rdy);
      chk("d_srcA", d_srcA, esa);
      chk("d_srcB", d_srcB, esb);
      chk("e_valid", e_valid, m_ev);
      chk("e_dstE", e_dstE, edste);
      chk("halted", halted, m_halted);
      chk("stall_count", stall_count, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("stall_count_sat", s_stall_count, (m_cnt > 3) ? 3 : m_cnt);
    end
    last_acc = 0;
    if (rs) begin
      m_ev = 0; m_halted = 0; m_cnt = 0;
    end else if (fl) begin
      m_ev = 0;
    end else if (hold) begin
      m_ev = 0; m_halted = 1;
    end else if (m_halted) begin
      m_ev = 0;
    end else if (haz) begin
      m_ev = 0; m_cnt++;
    end else if (v) begin
      m_ev = 1; m_e = dd; sb.push_back(dd); last_acc = 1;
    end else begin
      m_ev = 0;
    end
  endtask

  task automatic idle();
    step(0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 1);
  endtask

  // Monitor: whenever E presents an instruction, it must be the next one accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (e_valid === 1'b1) begin
          if (sb.size() == 0) begin
            chk("e_unexpected_valid", e_valid, 1'b0);
          end else begin
            mon_ex = sb.pop_front();
            chk("e_icode", e_icode, mon_ex.icode);
            chk("e_srcA", e_srcA, mon_ex.sa);
            chk("e_srcB", e_srcB, mon_ex.sb);
            chk("e_dstM", e_dstM, mon_ex.dm);
          end
        end else begin
          chk("bubble_icode", e_icode, 4'h1);
          chk("bubble_srcA", e_srcA, 4'hF);
          chk("bubble_srcB", e_srcB, 4'hF);
          chk("bubble_dstM", e_dstM, 4'hF);
        end
      end
    end
  end

  initial begin
    logic       cv, rs, fl;
    logic [3:0] ci, ca, cb;
    step(0, 4'h1, 4'hF, 4'hF, 0, 0, 1, 0);
    mon_en = 1;
    step(0, 4'h1, 4'hF, 4'hF, 0, 0, 1, 1);
    idle();
    chk("reset_e_valid", e_valid, 1'b0);
    chk("reset_stall", stall_count, 16'h0);

    // OPq rA=2 rB=3
    step(1, 4'h6, 4'h2, 4'h3, 0, 0, 0, 1);
    idle();
    chk("opq_srcA", e_srcA, 4'h2);
    chk("opq_srcB", e_srcB, 4'h3);
    chk("opq_dstE", e_dstE, 4'h3);
    chk("opq_dstM", e_dstM, 4'hF);

    // Load-use: mrmovq into r7 followed by OPq reading r7
    step(1, 4'h5, 4'h7, 4'h0, 0, 0, 0, 1);
    step(1, 4'h6, 4'h7, 4'h1, 0, 0, 0, 1);
    chk("lu_d_ready", d_ready, 1'b0);
    step(1, 4'h6, 4'h7, 4'h1, 0, 0, 0, 1);
    chk("lu_bubble", e_valid, 1'b0);
    chk("lu_stall", stall_count, 16'h1);
    idle();
    chk("lu_opq_srcA", e_srcA, 4'h7);

    // cmov gated by e_cnd
    step(1, 4'h2, 4'h1, 4'h5, 0, 0, 0, 1);
    idle();
    chk("cmov_nocnd", e_dstE, 4'hF);
    e_cnd = 1'b1;
    #1;
    chk("cmov_cnd", e_dstE, 4'h5);

    // popq rA=9
    step(1, 4'hB, 4'h9, 4'h0, 0, 0, 0, 1);
    step(0, 4'h1, 4'hF, 4'hF, 1, 0, 0, 1);
    chk("pop_srcA", e_srcA, 4'h4);
    chk("pop_srcB", e_srcB, 4'h4);
    chk("pop_dstE", e_dstE, 4'h4);
    chk("pop_dstM", e_dstM, 4'h9);

    // Hazard cycle flushed
    step(1, 4'h5, 4'h2, 4'h0, 0, 0, 0, 1);
    step(1, 4'h6, 4'h2, 4'h2, 0, 1, 0, 1);
    chk("flush_d_ready", d_ready, 1'b1);
    idle();
    chk("flush_bubble", e_valid, 1'b0);
    chk("flush_stall", stall_count, 16'h1);

    // Halt commits
    step(1, 4'h0, 4'hF, 4'hF, 0, 0, 0, 1);
    step(1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 1);
    chk("halt_in_e_ready", d_ready, 1'b0);
    step(1, 4'h6, 4'h1, 4'h2, 0, 0, 0, 1);
    chk("halt_sticky", halted, 1'b1);
    step(1, 4'h6, 4'h1, 4'h2, 0, 0, 0, 1);
    chk("halt_bubbles", e_valid, 1'b0);
    step(0, 4'h1, 4'hF, 4'hF, 0, 0, 1, 1);
    idle();
    chk("reset_halted", halted, 1'b0);
    chk("reset_stall2", stall_count, 16'h0);

    // Halt flushed in E
    step(1, 4'h0, 4'hF, 4'hF, 0, 0, 0, 1);
    step(1, 4'h1, 4'hF, 4'hF, 0, 1, 0, 1);
    idle();
    chk("halt_flushed", halted, 1'b0);

    // Drive the narrow counter past its ceiling
    for (int k = 0; k < 5; k++) begin
      step(1, 4'h5, 4'h1, 4'h0, 0, 0, 0, 1);
      step(1, 4'h6, 4'h1, 4'h1, 0, 0, 0, 1);
      step(1, 4'h6, 4'h1, 4'h1, 0, 0, 0, 1);
    end
    idle();
    chk("sat_narrow", s_stall_count, 2'h3);
    chk("sat_wide", stall_count, 16'h5);

    // Random streams; fetch holds an unaccepted instruction unless redirected
    cv = 0; ci = 4'h1; ca = 4'hF; cb = 4'hF;
    for (int n = 0; n < 4000; n++) begin
      rs = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 299) == 0);
      fl = ($urandom_range(0, 11) == 0);
      step(cv, ci, ca, cb, 1'($urandom_range(0, 1)), fl, rs, 1);
      if (!(cv && !last_acc && !fl && !rs && !m_halted)) begin
        cv = ($urandom_range(0, 3) != 0);
        ci = ($urandom_range(0, 63) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        ca = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        cb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
    end
    idle();
    idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
